// File: rtl/ppl_grid_census.sv
// Population census of the 48x36 people grid: snapshot on done, scan one cell per clock, report stats.
// Optional per-row maximum statistics are enabled with `define CENSUS_ROW_MAX_EN.
module ppl_grid_census #(
  parameter int COLS   = 48,
  parameter int ROWS   = 36,
  parameter int CELL_W = 4,
  parameter int CNT_W  = 11,
  parameter int SUM_W  = 14
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          done,
  input  logic [COLS*ROWS*CELL_W-1:0]   new_ppl_grid,
  output logic                          busy,
  output logic                          census_valid,
  output logic [CNT_W-1:0]              pop_count,
  output logic [CNT_W-1:0]              starving_count,
  output logic [SUM_W-1:0]              energy_sum,
  output logic                          extinct,
  output logic                          overrun
`ifdef CENSUS_ROW_MAX_EN
  ,
  output logic [5:0]                    max_row,
  output logic [5:0]                    max_row_pop
`endif
);

  localparam int CELLS  = COLS * ROWS;
  localparam int GRID_W = CELLS * CELL_W;

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t              r_state;
  state_t              w_nextState;

  logic [GRID_W-1:0]   r_snap;
  logic [CNT_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_popAcc;
  logic [CNT_W-1:0]    r_starvAcc;
  logic [SUM_W-1:0]    r_sumAcc;
  logic [CNT_W-1:0]    r_popCount;
  logic [CNT_W-1:0]    r_starvCount;
  logic [SUM_W-1:0]    r_energySum;
  logic                r_extinct;
  logic                r_overrun;

  logic [CELL_W-1:0]   w_cell;
  logic                w_occ;
  logic                w_starving;
  logic [CNT_W-1:0]    w_popNext;
  logic [CNT_W-1:0]    w_starvNext;
  logic [SUM_W-1:0]    w_sumNext;
  logic                w_lastCell;
  logic                w_start;

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (done) w_nextState = SCAN;
      SCAN:    if (w_lastCell) w_nextState = REPORT;
      REPORT:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    busy         = 1'b0;
    census_valid = 1'b0;
    case (r_state)
      SCAN:    busy = 1'b1;
      REPORT:  census_valid = 1'b1;
      default: ;
    endcase
  end

  // The snapshot shifts down one cell per clock, so the cell under scan is always the low nibble.
  assign w_cell      = r_snap[CELL_W-1:0];
  assign w_occ       = w_cell[3];
  assign w_starving  = w_occ && (w_cell[2:0] == 3'd0);
  assign w_popNext   = r_popAcc + CNT_W'(w_occ);
  assign w_starvNext = r_starvAcc + CNT_W'(w_starving);
  assign w_sumNext   = r_sumAcc + (w_occ ? SUM_W'(w_cell[2:0]) : SUM_W'(0));
  assign w_lastCell  = (r_idx == CNT_W'(CELLS - 1));
  assign w_start     = (r_state == IDLE) && done;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_snap       <= '0;
      r_idx        <= '0;
      r_popAcc     <= '0;
      r_starvAcc   <= '0;
      r_sumAcc     <= '0;
      r_popCount   <= '0;
      r_starvCount <= '0;
      r_energySum  <= '0;
      r_extinct    <= 1'b0;
    end else if (w_start) begin
      r_snap     <= new_ppl_grid;
      r_idx      <= '0;
      r_popAcc   <= '0;
      r_starvAcc <= '0;
      r_sumAcc   <= '0;
    end else if (r_state == SCAN) begin
      r_snap     <= r_snap >> CELL_W;
      r_idx      <= r_idx + CNT_W'(1);
      r_popAcc   <= w_popNext;
      r_starvAcc <= w_starvNext;
      r_sumAcc   <= w_sumNext;
      // Results land on the last scan edge so they are already visible in the REPORT cycle.
      if (w_lastCell) begin
        r_popCount   <= w_popNext;
        r_starvCount <= w_starvNext;
        r_energySum  <= w_sumNext;
        r_extinct    <= (w_popNext == '0);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in)
      r_overrun <= 1'b0;
    else if (done && (r_state != IDLE))
      r_overrun <= 1'b1;
  end

  assign pop_count      = r_popCount;
  assign starving_count = r_starvCount;
  assign energy_sum     = r_energySum;
  assign extinct        = r_extinct;
  assign overrun        = r_overrun;

`ifdef CENSUS_ROW_MAX_EN
  logic [5:0] r_col;
  logic [5:0] r_row;
  logic [5:0] r_rowCnt;
  logic [5:0] r_bestRow;
  logic [5:0] r_bestPop;
  logic [5:0] r_maxRow;
  logic [5:0] r_maxRowPop;
  logic [5:0] w_rowTotal;
  logic       w_rowEnd;
  logic       w_better;
  logic [5:0] w_bestRowNext;
  logic [5:0] w_bestPopNext;

  // Strictly-greater comparison keeps the lowest row index on ties.
  assign w_rowTotal    = ((r_col == 6'd0) ? 6'd0 : r_rowCnt) + 6'(w_occ);
  assign w_rowEnd      = (r_col == 6'(COLS - 1));
  assign w_better      = w_rowEnd && (w_rowTotal > r_bestPop);
  assign w_bestRowNext = w_better ? r_row : r_bestRow;
  assign w_bestPopNext = w_better ? w_rowTotal : r_bestPop;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_col       <= '0;
      r_row       <= '0;
      r_rowCnt    <= '0;
      r_bestRow   <= '0;
      r_bestPop   <= '0;
      r_maxRow    <= '0;
      r_maxRowPop <= '0;
    end else if (w_start) begin
      r_col     <= '0;
      r_row     <= '0;
      r_rowCnt  <= '0;
      r_bestRow <= '0;
      r_bestPop <= '0;
    end else if (r_state == SCAN) begin
      r_rowCnt  <= w_rowTotal;
      r_bestRow <= w_bestRowNext;
      r_bestPop <= w_bestPopNext;
      r_col     <= w_rowEnd ? 6'd0 : r_col + 6'd1;
      r_row     <= w_rowEnd ? r_row + 6'd1 : r_row;
      if (w_lastCell) begin
        r_maxRow    <= w_bestRowNext;
        r_maxRowPop <= w_bestPopNext;
      end
    end
  end

  assign max_row     = r_maxRow;
  assign max_row_pop = r_maxRowPop;
`endif

endmodule

// File: tb/tb_ppl_grid_census.sv
// Scoreboard bench for ppl_grid_census: stimulus pushes expected results, a monitor checks each census_valid.
// Row-maximum checks are compiled in when CENSUS_ROW_MAX_EN is defined.
module tb_ppl_grid_census;

  localparam int COLS  = 48;
  localparam int ROWS  = 36;
  localparam int CELLS = COLS * ROWS;
  localparam int GW    = CELLS * 4;

  typedef struct {
    int pop;
    int starv;
    int sum;
    int ext;
    int maxRow;
    int maxRowPop;
  } expect_t;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          done   = 1'b0;
  logic [GW-1:0] new_ppl_grid = '0;
  logic          busy;
  logic          census_valid;
  logic [10:0]   pop_count;
  logic [10:0]   starving_count;
  logic [13:0]   energy_sum;
  logic          extinct;
  logic          overrun;
`ifdef CENSUS_ROW_MAX_EN
  logic [5:0]    max_row;
  logic [5:0]    max_row_pop;
`endif

  int nAssert = 0;
  int nFail   = 0;
  expect_t expQ[$];
  expect_t monExp;
  int lastPop = 0;

  ppl_grid_census dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .done          (done),
    .new_ppl_grid  (new_ppl_grid),
    .busy          (busy),
    .census_valid  (census_valid),
    .pop_count     (pop_count),
    .starving_count(starving_count),
    .energy_sum    (energy_sum),
    .extinct       (extinct),
    .overrun       (overrun)
`ifdef CENSUS_ROW_MAX_EN
    ,
    .max_row       (max_row),
    .max_row_pop   (max_row_pop)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nAssert++;
    if (actual != expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every census_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk_in) begin
    if (census_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected census_valid", 1, 0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("pop_count", int'(pop_count), monExp.pop);
        checkOutput("starving_count", int'(starving_count), monExp.starv);
        checkOutput("energy_sum", int'(energy_sum), monExp.sum);
        checkOutput("extinct", int'(extinct), monExp.ext);
        checkOutput("busy in report", int'(busy), 0);
`ifdef CENSUS_ROW_MAX_EN
        checkOutput("max_row", int'(max_row), monExp.maxRow);
        checkOutput("max_row_pop", int'(max_row_pop), monExp.maxRowPop);
`endif
      end
    end
  end

  function automatic logic [GW-1:0] fillGrid(input logic [3:0] v);
    logic [GW-1:0] g;
    for (int i = 0; i < CELLS; i++) g[i*4 +: 4] = v;
    return g;
  endfunction

  // Pulse done with the given grid; optionally disturb the grid and pulse done again mid-scan.
  task automatic applyStimulus(input logic [GW-1:0] grid, input expect_t e, input int disturbAt);
    int cyc = 0;
    int busyCnt = 0;
    bit seen = 1'b0;
    @(posedge clk_in); #1;
    new_ppl_grid = grid;
    done = 1'b1;
    expQ.push_back(e);
    @(posedge clk_in); #1;
    done = 1'b0;
    for (int k = 1; k <= 2000 && !seen; k++) begin
      @(negedge clk_in);
      if (busy) busyCnt++;
      if (census_valid) begin
        seen = 1'b1;
        cyc = k;
      end
      if (k == 1000) checkOutput("hold pop during scan", int'(pop_count), lastPop);
      if (k == disturbAt) begin
        new_ppl_grid = fillGrid(4'hF);
        done = 1'b1;
      end
      if (k == disturbAt + 1) done = 1'b0;
    end
    checkOutput("census completed", int'(seen), 1);
    checkOutput("valid latency", cyc, 1729);
    checkOutput("busy cycles", busyCnt, 1728);
    @(negedge clk_in);
    checkOutput("valid is one cycle", int'(census_valid), 0);
    checkOutput("scoreboard drained", expQ.size(), 0);
    lastPop = e.pop;
  endtask

  logic [GW-1:0] gSparse;
  logic [GW-1:0] gOver;
  logic [GW-1:0] gRows;

  initial begin
    int vcnt;
    gSparse = '0;
    gSparse[0*4 +: 4]    = 4'h8;
    gSparse[47*4 +: 4]   = 4'h8;
    gSparse[1727*4 +: 4] = 4'h8;
    gSparse[100*4 +: 4]  = 4'hB;
    gSparse[5*4 +: 4]    = 4'h7;

    gOver = '0;
    gOver[10*4 +: 4] = 4'hC;
    gOver[20*4 +: 4] = 4'h9;

    // Rows 3 and 7 hold five each, row 10 four, row 0 two; row 7 cells carry energy 1.
    gRows = '0;
    for (int c = 0; c < 5; c++) gRows[(3*COLS + c*9)*4 +: 4] = 4'h8;
    for (int c = 0; c < 5; c++) gRows[(7*COLS + c*2)*4 +: 4] = 4'h9;
    for (int c = 0; c < 4; c++) gRows[(10*COLS + c)*4 +: 4] = 4'h8;
    gRows[0*4 +: 4]  = 4'h8;
    gRows[30*4 +: 4] = 4'h8;

    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset census_valid", int'(census_valid), 0);
    checkOutput("reset pop", int'(pop_count), 0);
    checkOutput("reset starving", int'(starving_count), 0);
    checkOutput("reset energy", int'(energy_sum), 0);
    checkOutput("reset extinct", int'(extinct), 0);
    checkOutput("reset overrun", int'(overrun), 0);
    rst_in = 1'b0;

    applyStimulus('0, '{pop:0, starv:0, sum:0, ext:1, maxRow:0, maxRowPop:0}, -1);
    applyStimulus(fillGrid(4'hF), '{pop:1728, starv:0, sum:12096, ext:0, maxRow:0, maxRowPop:48}, -1);
    applyStimulus(gSparse, '{pop:4, starv:3, sum:3, ext:0, maxRow:0, maxRowPop:2}, -1);
    checkOutput("no overrun yet", int'(overrun), 0);

    applyStimulus(gOver, '{pop:2, starv:0, sum:5, ext:0, maxRow:0, maxRowPop:2}, 300);
    checkOutput("overrun set", int'(overrun), 1);
    applyStimulus(fillGrid(4'hF), '{pop:1728, starv:0, sum:12096, ext:0, maxRow:0, maxRowPop:48}, -1);
    checkOutput("overrun sticky", int'(overrun), 1);

    // Abort a scan with reset; no result may be reported for it.
    @(posedge clk_in); #1;
    new_ppl_grid = fillGrid(4'hA);
    done = 1'b1;
    @(posedge clk_in); #1;
    done = 1'b0;
    vcnt = 0;
    for (int k = 1; k <= 500; k++) begin
      @(negedge clk_in);
      if (census_valid) vcnt++;
    end
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort pop", int'(pop_count), 0);
    checkOutput("abort energy", int'(energy_sum), 0);
    checkOutput("abort extinct", int'(extinct), 0);
    checkOutput("abort overrun", int'(overrun), 0);
    for (int k = 1; k <= 1800; k++) begin
      @(negedge clk_in);
      if (census_valid) vcnt++;
    end
    checkOutput("no valid after abort", vcnt, 0);
    lastPop = 0;

    applyStimulus(gSparse, '{pop:4, starv:3, sum:3, ext:0, maxRow:0, maxRowPop:2}, -1);
    applyStimulus(gRows, '{pop:16, starv:11, sum:5, ext:0, maxRow:3, maxRowPop:5}, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
